lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store sequencer for the RV32C core: executes c.lw/c.sw/c.lwsp/c.swsp as multi-cycle ops.
//  Takes the ALU-computed address plus store data/dest reg from decode, runs a req/ack data-memory
//  transaction, stalls pc/regfile while busy, then issues one regfile writeback for loads.
//  Sits between decoder/alu and regs; the pc advance is gated by ~stall.
// PARAMETERS
//  TIMEOUT  16  max REQ cycles without mem_ack before abort (used only with LSU_TIMEOUT_EN)
// PORTS
//  clock        in   1   clock
//  reset        in   1   synchronous, active-high
//  issue_valid  in   1   current instruction is a load/store
//  issue_store  in   1   1=store, 0=load
//  issue_addr   in   32  effective address (ALU out)
//  issue_wdata  in   32  store data (Rs_data)
//  issue_rd     in   5   load destination register
//  stall        out  1   hold pc and suppress normal regfile write (combinational)
//  busy         out  1   state != IDLE
//  mem_req      out  1   memory request, held until mem_ack
//  mem_we       out  1   1=write
//  mem_addr     out  32  word address (bits[1:0]=0)
//  mem_wdata    out  32  write data
//  mem_ack      in   1   memory completed; sampled only while mem_req=1
//  mem_rdata    in   32  read data, valid with mem_ack on loads
//  wb_en        out  1   load writeback strobe (1 cycle)
//  wb_rd        out  5   writeback register
//  wb_data      out  32  writeback data
//  fault        out  1   1-cycle abort pulse
//  fault_code   out  2   01 misaligned, 10 timeout; 00 otherwise
// BEHAVIOUR
//  Reset: state IDLE; all registered outputs 0 (mem_*, wb_*, fault, fault_code, busy).
//  Reset mid-op: next edge forces IDLE, mem_req=0; transaction abandoned, no wb_en.
//  States IDLE -> REQ -> DONE -> IDLE; DONE always lasts exactly 1 cycle.
//  stall = (IDLE & issue_valid) | REQ. In DONE stall=0, so pc advances past the instruction;
//   issue_valid is ignored in REQ and DONE (the same instruction is still presented).
//  IDLE & issue_valid & addr[1:0]==0: latch addr/wdata/rd/store -> REQ.
//  IDLE & issue_valid & addr[1:0]!=0: no memory access -> DONE with fault=1, code=01, wb_en=0.
//  REQ: mem_req=1, mem_we=store; addr/wdata stable until ack. On mem_ack -> DONE;
//   load: wb_data<=mem_rdata, wb_en=1 in DONE. Store: no wb_en.
//  mem_ack outside REQ is ignored. Ack in first REQ cycle gives minimum latency:
//   issue T, REQ T+1, DONE T+2 (3 cycles/op); each extra wait cycle adds 1.
//  Load to x0: wb_en still asserted; regs discards the write.
//  wb_en, fault are 1-cycle pulses in DONE only; mem_req drops in DONE.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: counter clears on REQ entry, +1 per REQ cycle without ack;
//   after TIMEOUT such cycles -> DONE with fault=1, code=10, no wb_en. Ack on the
//   timeout cycle wins (normal completion). Not defined: REQ waits indefinitely,
//   no counter, fault_code 10 is never produced.
// TESTING
//  Load addr 0x100, ack 1st REQ cycle, rdata 0xDEADBEEF, rd=9 -> stall 2 cycles, wb_en@T+2, wb_rd=9, wb_data=0xDEADBEEF.
//  Store addr 0x204 wdata 0x12345678, ack after 3 wait cycles -> mem_we=1 held 4 cycles, no wb_en, stall 5 cycles.
//  Load addr 0x102 -> no mem_req, fault=1 code=01 at T+1, stall 1 cycle, no wb_en.
//  Reset asserted in REQ with mem_ack low -> next cycle IDLE, mem_req=0, wb_en never asserted.
//  Spurious mem_ack in IDLE, then back-to-back load/store -> ack ignored; each op takes 3 cycles.
//  LSU_TIMEOUT_EN, TIMEOUT=16, ack never -> 16 REQ cycles, then fault=1 code=10, stall drops.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencer for the RV32C core: one req/ack data-memory transaction per c.lw/c.sw,
// stalling the front end while busy. Optional REQ watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_store,
  input  logic [31:0] issue_addr,
  input  logic [31:0] issue_wdata,
  input  logic [4:0]  issue_rd,
  output logic        stall,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic        busy_q, busy_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        fault_q, fault_d;
  logic [1:0]  fault_code_q, fault_code_d;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    wb_en_d      = 1'b0;
    fault_d      = 1'b0;
    fault_code_d = 2'b00;
`ifdef LSU_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (issue_valid) begin
          if (issue_addr[1:0] == 2'b00) begin
            state_d     = StReq;
            store_d     = issue_store;
            mem_addr_d  = {issue_addr[31:2], 2'b00};
            mem_wdata_d = issue_wdata;
            wb_rd_d     = issue_rd;
            mem_req_d   = 1'b1;
            mem_we_d    = issue_store;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_d   = '0;
`endif
          end else begin
            // Misaligned: skip memory entirely, report through DONE
            state_d      = StDone;
            fault_d      = 1'b1;
            fault_code_d = 2'b01;
          end
        end
      end
      StReq: begin
        if (mem_ack) begin
          state_d = StDone;
          wb_en_d = ~store_q;
          if (!store_q) wb_data_d = mem_rdata;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = store_q;
`ifdef LSU_TIMEOUT_EN
          if (tmo_cnt_q == CntW'(TIMEOUT - 1)) begin
            state_d      = StDone;
            mem_req_d    = 1'b0;
            mem_we_d     = 1'b0;
            fault_d      = 1'b1;
            fault_code_d = 2'b10;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      store_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_en_q      <= wb_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign stall      = ((state_q == StIdle) & issue_valid) | (state_q == StReq);
  assign busy       = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wb_en      = wb_en_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a transaction-level model expands each op into its per-cycle output
// timeline, and one negedge process compares the DUT against it.
module tb_lsu_ctrl;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_store;
  logic [31:0] issue_addr, issue_wdata;
  logic [4:0]  issue_rd;
  logic        stall, busy, mem_req, mem_we, mem_ack, wb_en, fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  fault_code;

  lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_store(issue_store),
    .issue_addr(issue_addr), .issue_wdata(issue_wdata), .issue_rd(issue_rd), .stall(stall),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault), .fault_code(fault_code)
  );

  always #5 clock = ~clock;

  int n_vec = 0, n_err = 0;
  bit chk_en = 0;

  // Expected outputs for the current cycle
  logic        e_stall, e_busy, e_req, e_we, e_wb, e_fault;
  logic [31:0] e_addr, e_wdata, e_wdat;
  logic [4:0]  e_rd;
  logic [1:0]  e_code;

  // Observation counters, written only by the compare process
  int obs_stall = 0, obs_we = 0, obs_wb = 0, obs_req = 0, obs_fault = 0;
  logic [31:0] last_wb_data = '0;
  logic [4:0]  last_wb_rd = '0;
  logic [1:0]  last_code = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("wb_en", 32'(wb_en), 32'(e_wb));
      chk("fault", 32'(fault), 32'(e_fault));
      chk("fault_code", 32'(fault_code), 32'(e_code));
      if (e_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_wb) begin
        chk("wb_rd", 32'(wb_rd), 32'(e_rd));
        chk("wb_data", wb_data, e_wdat);
      end
      if (stall) obs_stall++;
      if (mem_we) obs_we++;
      if (mem_req) obs_req++;
      if (fault) begin obs_fault++; last_code = fault_code; end
      if (wb_en) begin obs_wb++; last_wb_data = wb_data; last_wb_rd = wb_rd; end
    end
  end

  task automatic slot();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_idle(input logic s);
    e_stall = s; e_busy = 0; e_req = 0; e_we = 0; e_wb = 0; e_fault = 0; e_code = 2'b00;
    e_addr = '0; e_wdata = '0; e_rd = '0; e_wdat = '0;
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) begin
      issue_valid = 0; mem_ack = ack; mem_rdata = $urandom;
      exp_idle(0);
      slot();
    end
    mem_ack = 0;
  endtask

  // One load/store: waits = REQ cycles before the acking one; waits >= TIMEOUT means no ack
  task automatic op(input bit st, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [4:0] rd, input logic [31:0] rdata, input int waits);
    int reqs;
    bit tmo;
    issue_valid = 1; issue_store = st; issue_addr = addr; issue_wdata = wdata; issue_rd = rd;
    mem_ack = 0; mem_rdata = $urandom;
    exp_idle(1);
    slot();
    if (addr[1:0] != 2'b00) begin
      exp_idle(0); e_busy = 1; e_fault = 1; e_code = 2'b01;
      slot();
    end else begin
      reqs = waits + 1;
      tmo  = 0;
`ifdef LSU_TIMEOUT_EN
      if (waits >= TIMEOUT) begin reqs = TIMEOUT; tmo = 1; end
`endif
      for (int k = 0; k < reqs; k++) begin
        mem_ack = !tmo && (k == reqs - 1);
        mem_rdata = mem_ack ? rdata : $urandom;
        exp_idle(1); e_busy = 1; e_req = 1; e_we = st; e_addr = addr; e_wdata = wdata;
        slot();
      end
      mem_ack = 0; mem_rdata = $urandom;
      exp_idle(0); e_busy = 1;
      if (tmo) begin e_fault = 1; e_code = 2'b10; end
      else begin e_wb = !st; e_rd = rd; e_wdat = rdata; end
      slot();
    end
    issue_valid = 0;
  endtask

  int b_stall, b_we, b_wb, b_req, b_fault;
  task automatic snap();
    b_stall = obs_stall; b_we = obs_we; b_wb = obs_wb; b_req = obs_req; b_fault = obs_fault;
  endtask

  initial begin
    reset = 1; issue_valid = 0; issue_store = 0; issue_addr = '0; issue_wdata = '0;
    issue_rd = '0; mem_ack = 0; mem_rdata = '0;
    exp_idle(0);
    slot();
    chk_en = 1;
    slot();
    reset = 0;
    idle(2, 0);

    // Aligned load, ack in first REQ cycle
    snap();
    op(0, 32'h100, 32'h0, 5'd9, 32'hDEADBEEF, 0);
    chk("load_stall_cycles", 32'(obs_stall - b_stall), 32'd2);
    chk("load_wb_count", 32'(obs_wb - b_wb), 32'd1);
    chk("load_wb_data", last_wb_data, 32'hDEADBEEF);
    chk("load_wb_rd", 32'(last_wb_rd), 32'd9);

    // Store with three wait cycles
    snap();
    op(1, 32'h204, 32'h12345678, 5'd3, 32'h0, 3);
    chk("store_we_cycles", 32'(obs_we - b_we), 32'd4);
    chk("store_stall_cycles", 32'(obs_stall - b_stall), 32'd5);
    chk("store_wb_count", 32'(obs_wb - b_wb), 32'd0);

    // Misaligned load
    snap();
    op(0, 32'h102, 32'h0, 5'd4, 32'h0, 0);
    chk("misal_req_cycles", 32'(obs_req - b_req), 32'd0);
    chk("misal_fault_count", 32'(obs_fault - b_fault), 32'd1);
    chk("misal_code", 32'(last_code), 32'd1);
    chk("misal_stall_cycles", 32'(obs_stall - b_stall), 32'd1);
    idle(1, 0);

    // Reset in the middle of a REQ wait
    snap();
    issue_valid = 1; issue_store = 0; issue_addr = 32'h300; issue_rd = 5'd7;
    exp_idle(1);
    slot();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) reset = 1;
      mem_ack = 0;
      exp_idle(1); e_busy = 1; e_req = 1; e_we = 0; e_addr = 32'h300; e_wdata = issue_wdata;
      slot();
    end
    reset = 0;
    idle(3, 0);
    chk("reset_wb_count", 32'(obs_wb - b_wb), 32'd0);

    // Spurious ack in idle, then back-to-back load/store and a load to x0
    idle(2, 1);
    snap();
    op(0, 32'h400, 32'h0, 5'd0, 32'hA5A5_0001, 0);
    op(1, 32'h404, 32'hCAFEF00D, 5'd1, 32'h0, 0);
    op(0, 32'h408, 32'h0, 5'd31, 32'h0F0F_1234, 1);
    chk("b2b_stall_cycles", 32'(obs_stall - b_stall), 32'd7);
    chk("b2b_wb_count", 32'(obs_wb - b_wb), 32'd2);
    chk("b2b_last_wb_data", last_wb_data, 32'h0F0F_1234);

`ifdef LSU_TIMEOUT_EN
    snap();
    op(0, 32'h500, 32'h0, 5'd2, 32'h0, 1000);
    chk("tmo_stall_cycles", 32'(obs_stall - b_stall), 32'(TIMEOUT + 1));
    chk("tmo_code", 32'(last_code), 32'd2);
    chk("tmo_wb_count", 32'(obs_wb - b_wb), 32'd0);
    // Ack on the final countable cycle still completes normally
    op(0, 32'h504, 32'h0, 5'd6, 32'h7777_8888, TIMEOUT - 1);
    chk("tmo_edge_wb_data", last_wb_data, 32'h7777_8888);
`else
    // Without the watchdog a long wait must complete normally
    snap();
    op(0, 32'h500, 32'h0, 5'd2, 32'h1357_9BDF, 20);
    chk("long_wait_wb_data", last_wb_data, 32'h1357_9BDF);
    chk("long_wait_fault_count", 32'(obs_fault - b_fault), 32'd0);
`endif
    idle(2, 0);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
